character_controller: RTL

CHARACTER_CONTROLLER -- requirements
Module: character_controller

---
 rtl/character_controller.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/character_controller.sv
`default_nettype none
// ============================================================================
// Module   : character_controller
// Purpose  : Grid-stepping character movement controller. A frame tick is
//            derived from frame_clk. On each tick a keycode request either
//            turns the character in place (TURN), starts or continues a
//            one-tile walk (WALK), or leaves it standing (IDLE).
// Ports    : Clk              - system clock
//            Reset            - asynchronous active-high reset
//            frame_clk        - frame signal, asynchronous to Clk
//            keycode[7:0]     - USB HID keycode (0x00 = no key)
//            Direction[1:0]   - facing: 00 down, 01 up, 10 left, 11 right
//            Character_Moving - high while a step is in progress
//            Anim_Frame[1:0]  - walk-cycle sprite index
//            PosX[9:0]        - world X in pixels
//            PosY[9:0]        - world Y in pixels
//            Step_Done        - one-Clk pulse when a step completes
// Revision : 1.0 - initial release
// ============================================================================
module character_controller #(
  parameter int TILE        = 16,
  parameter int MAP_TILES   = 32,
  parameter int TURN_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [1:0] Direction,
  output logic       Character_Moving,
  output logic [1:0] Anim_Frame,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       Step_Done
);

  localparam int PIX_W  = $clog2(TILE);
  localparam int TURN_W = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;

  localparam logic [9:0]        C_POS_MAX   = 10'((MAP_TILES - 1) * TILE);
  localparam logic [9:0]        C_POS_HOME  = 10'((MAP_TILES / 2) * TILE);
  localparam logic [9:0]        C_TILE      = 10'(TILE);
  localparam logic [PIX_W-1:0]  C_PIX_LAST  = PIX_W'(TILE - 1);
  localparam logic [PIX_W-1:0]  C_ANIM_MASK = PIX_W'(TILE / 4 - 1);
  localparam logic [TURN_W-1:0] C_TURN_LAST = TURN_W'(TURN_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_WALK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          sync_q, sync_d;
  logic [1:0]          dir_q, dir_d;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [1:0]          anim_q, anim_d;
  logic [9:0]          posx_q, posx_d;
  logic [9:0]          posy_q, posy_d;
  logic                moving_q, moving_d;
  logic                step_done_q, step_done_d;

  logic                tick;
  logic                req_valid;
  logic [1:0]          req_dir;
  logic [9:0]          posx_step, posy_step;
  logic [PIX_W-1:0]    pix_next;
  logic                walk_px;

  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] holds the previous
  // synchronised level so the rising edge becomes a single-Clk tick.
  assign sync_d   = {sync_q[1:0], frame_clk};
  assign tick     = sync_q[1] & ~sync_q[2];
  assign pix_next = pix_cnt_q + PIX_W'(1);

  // Target tile lies outside the map. Positions are tile aligned when this
  // is evaluated, so comparing against the edge tile is sufficient.
  function automatic logic is_blocked(input logic [1:0] dir,
                                      input logic [9:0] x,
                                      input logic [9:0] y);
    case (dir)
      2'b00:   is_blocked = (y >= C_POS_MAX);
      2'b01:   is_blocked = (y < C_TILE);
      2'b10:   is_blocked = (x < C_TILE);
      default: is_blocked = (x >= C_POS_MAX);
    endcase
  endfunction

  always_comb begin
    req_valid = 1'b1;
    req_dir   = 2'b00;
    case (keycode)
      8'h16:   req_dir = 2'b00;
      8'h1A:   req_dir = 2'b01;
      8'h04:   req_dir = 2'b10;
      8'h07:   req_dir = 2'b11;
      default: req_valid = 1'b0;
    endcase
  end

  // Position after moving one pixel in the current facing.
  always_comb begin
    posx_step = posx_q;
    posy_step = posy_q;
    case (dir_q)
      2'b00:   posy_step = posy_q + 10'd1;
      2'b01:   posy_step = posy_q - 10'd1;
      2'b10:   posx_step = posx_q - 10'd1;
      default: posx_step = posx_q + 10'd1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    turn_cnt_d  = turn_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    anim_d      = anim_q;
    posx_d      = posx_q;
    posy_d      = posy_q;
    step_done_d = 1'b0;
    walk_px     = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_dir != dir_q) begin
              dir_d      = req_dir;
              turn_cnt_d = '0;
              state_d    = ST_TURN;
            end else if (!is_blocked(dir_q, posx_q, posy_q)) begin
              walk_px = 1'b1;
            end
          end
        end
        ST_TURN: begin
          if (turn_cnt_q == C_TURN_LAST) begin
            if (req_valid && (req_dir == dir_q) && !is_blocked(dir_q, posx_q, posy_q))
              walk_px = 1'b1;
            else
              state_d = ST_IDLE;
          end else begin
            turn_cnt_d = turn_cnt_q + TURN_W'(1);
          end
        end
        default: walk_px = 1'b1;  // mid-step: keycode is ignored
      endcase
    end

    // Starting a step moves its first pixel on the same tick.
    if (walk_px) begin
      state_d   = ST_WALK;
      posx_d    = posx_step;
      posy_d    = posy_step;
      pix_cnt_d = pix_next;  // wraps to 0 on the last pixel
      if ((pix_next & C_ANIM_MASK) == '0)
        anim_d = anim_q + 2'd1;
      if (pix_cnt_q == C_PIX_LAST) begin
        step_done_d = 1'b1;
        // Continuing straight keeps WALK; anything else leaves the walk.
        if (!(req_valid && (req_dir == dir_q) && !is_blocked(dir_q, posx_step, posy_step))) begin
          anim_d = 2'd0;
          if (req_valid && (req_dir != dir_q)) begin
            dir_d      = req_dir;
            turn_cnt_d = '0;
            state_d    = ST_TURN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    end

    moving_d = (state_d == ST_WALK);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      sync_q      <= '0;
      dir_q       <= 2'b00;
      turn_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      anim_q      <= 2'd0;
      posx_q      <= C_POS_HOME;
      posy_q      <= C_POS_HOME;
      moving_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      dir_q       <= dir_d;
      turn_cnt_q  <= turn_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      anim_q      <= anim_d;
      posx_q      <= posx_d;
      posy_q      <= posy_d;
      moving_q    <= moving_d;
      step_done_q <= step_done_d;
    end
  end

  assign Direction        = dir_q;
  assign Character_Moving = moving_q;
  assign Anim_Frame       = anim_q;
  assign PosX             = posx_q;
  assign PosY             = posy_q;
  assign Step_Done        = step_done_q;

endmodule
`default_nettype wire
